// File: rtl/vector_issue_sequencer.sv
// ----------------------------------------------------------------------------
// vector_issue_sequencer
//
// Walks the element range of one decoded vector instruction, LANES elements
// per cycle. For each element group it presents the lane-0 element index, the
// lane-active mask and the register-group offsets for the vs1/vs2/vd offset
// muxes. When the instruction finishes it pulses done so decode can issue the
// next instruction.
//
// Optional feature macro: VECTOR_SEQ_REDUCTION_EN
//   When defined, reduction instructions get log2(LANES) lane-fold cycles
//   (red_step / red_stage) after the last element group. When undefined,
//   reduction_ena is ignored and red_step / red_stage are tied to 0.
//
// Parameters
//   LANES  elements per cycle (power of two, >= 2)
//   VLENB  vector register length in bytes (power of two)
//   VL_W   width of vl, vstart and element indices
//
// Ports
//   CLK, nRST      clock, asynchronous active-low reset
//   start          begin instruction (sampled only while idle)
//   vl, vstart     vector length and first element (sampled with start)
//   sew            element width 00=e8 01=e16 10=e32 (11 reserved -> err)
//   vd_widen       destination EEW is 2*SEW
//   reduction_ena  instruction is a reduction
//   stall          downstream back-pressure, freezes the group outputs
//   flush          abort the current instruction
//   busy           sequencer is not idle
//   ena            current element group valid
//   elem_idx       element index of lane 0
//   lane_active    bit i set when elem_idx+i < vl
//   vs_reg_off     source register offset within the register group
//   vd_reg_off     destination register offset within the register group
//   last           current group is the final one
//   red_step       reduction fold cycle valid
//   red_stage      fold stage index
//   done           one-cycle completion pulse
//   err            one-cycle pulse for a start with reserved sew
// ----------------------------------------------------------------------------
module vector_issue_sequencer #(
  parameter int LANES = 2,
  parameter int VLENB = 16,
  parameter int VL_W  = 8
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       start,
  input  logic [VL_W-1:0]            vl,
  input  logic [VL_W-1:0]            vstart,
  input  logic [1:0]                 sew,
  input  logic                       vd_widen,
  input  logic                       reduction_ena,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       busy,
  output logic                       ena,
  output logic [VL_W-1:0]            elem_idx,
  output logic [LANES-1:0]           lane_active,
  output logic [2:0]                 vs_reg_off,
  output logic [2:0]                 vd_reg_off,
  output logic                       last,
  output logic                       red_step,
  output logic [$clog2(LANES)-1:0]   red_stage,
  output logic                       done,
  output logic                       err
);

  localparam int RED_W      = $clog2(LANES);
  localparam int VLENB_LOG2 = $clog2(VLENB);
  localparam logic [VL_W:0]   LANES_EXT = (VL_W+1)'(LANES);
  localparam logic [VL_W-1:0] LANES_IDX = VL_W'(LANES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RED  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [VL_W-1:0] elem_idx_q, elem_idx_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [1:0]      sew_q, sew_d;
  logic            widen_q, widen_d;
  logic            err_q, err_d;
  logic            last_raw;

`ifdef VECTOR_SEQ_REDUCTION_EN
  localparam logic [RED_W-1:0] RED_LAST = RED_W'(RED_W - 1);
  logic             red_q, red_d;
  logic [RED_W-1:0] red_stage_q, red_stage_d;
`else
  logic             unused_red;
  assign unused_red = reduction_ena;
`endif

  // The final-group test is done one bit wider than the index so that a
  // group near the top of the index range cannot wrap and look non-final.
  assign last_raw = ({1'b0, elem_idx_q} + LANES_EXT) >= {1'b0, vl_q};

  // Next-state logic. Flush overrides everything, including a start or a
  // group acceptance in the same cycle, and never produces a done pulse.
  always_comb begin
    state_d    = state_q;
    elem_idx_d = elem_idx_q;
    vl_d       = vl_q;
    sew_d      = sew_q;
    widen_d    = widen_q;
    err_d      = 1'b0;
`ifdef VECTOR_SEQ_REDUCTION_EN
    red_d       = red_q;
    red_stage_d = red_stage_q;
`endif
    if (flush) begin
      state_d = S_IDLE;
`ifdef VECTOR_SEQ_REDUCTION_EN
      red_stage_d = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (sew == 2'b11) begin
              err_d = 1'b1;
            end else begin
              vl_d       = vl;
              elem_idx_d = vstart;
              sew_d      = sew;
              widen_d    = vd_widen;
`ifdef VECTOR_SEQ_REDUCTION_EN
              red_d       = reduction_ena;
              red_stage_d = '0;
`endif
              // An empty element range completes without any group.
              state_d = (vstart < vl) ? S_RUN : S_DONE;
            end
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (last_raw) begin
`ifdef VECTOR_SEQ_REDUCTION_EN
              state_d = red_q ? S_RED : S_DONE;
`else
              state_d = S_DONE;
`endif
            end else begin
              elem_idx_d = elem_idx_q + LANES_IDX;
            end
          end
        end
        S_RED: begin
`ifdef VECTOR_SEQ_REDUCTION_EN
          if (!stall) begin
            if (red_stage_q == RED_LAST) begin
              state_d     = S_DONE;
              red_stage_d = '0;
            end else begin
              red_stage_d = red_stage_q + RED_W'(1);
            end
          end
`else
          state_d = S_IDLE;
`endif
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      elem_idx_q <= '0;
      vl_q       <= '0;
      sew_q      <= '0;
      widen_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_idx_q <= elem_idx_d;
      vl_q       <= vl_d;
      sew_q      <= sew_d;
      widen_q    <= widen_d;
      err_q      <= err_d;
    end
  end

`ifdef VECTOR_SEQ_REDUCTION_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      red_q       <= 1'b0;
      red_stage_q <= '0;
    end else begin
      red_q       <= red_d;
      red_stage_q <= red_stage_d;
    end
  end

  assign red_step  = (state_q == S_RED);
  assign red_stage = red_stage_q;
`else
  assign red_step  = 1'b0;
  assign red_stage = '0;
`endif

  // Lane i is live while its element is still inside vl; vl_q is cleared by
  // reset so the mask reads zero out of reset.
  always_comb begin
    lane_active = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_active[i] = ({1'b0, elem_idx_q} + (VL_W+1)'(i)) < {1'b0, vl_q};
    end
  end

  // A register holds VLENB >> eew elements, so the register offset inside
  // the group is the element index shifted by log2(VLENB) - eew. The shift
  // is clamped at zero for configurations where eew exceeds log2(VLENB).
  int              vs_shift;
  int              vd_shift;
  logic [VL_W-1:0] vs_full;
  logic [VL_W-1:0] vd_full;

  always_comb begin
    vs_shift = VLENB_LOG2 - int'(sew_q);
    vd_shift = VLENB_LOG2 - int'(sew_q) - int'(widen_q);
    if (vs_shift < 0) vs_shift = 0;
    if (vd_shift < 0) vd_shift = 0;
    vs_full = elem_idx_q >> vs_shift;
    vd_full = elem_idx_q >> vd_shift;
  end

  assign vs_reg_off = vs_full[2:0];
  assign vd_reg_off = vd_full[2:0];

  assign busy     = (state_q != S_IDLE);
  assign ena      = (state_q == S_RUN);
  assign last     = (state_q == S_RUN) & last_raw;
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign elem_idx = elem_idx_q;

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vector_issue_sequencer
//
// Directed-vector bench for vector_issue_sequencer (LANES=2, VLENB=16,
// VL_W=8). Inputs change and outputs are sampled on the falling clock edge.
// Expected values are hand-computed and held in small tables.
// ----------------------------------------------------------------------------
module tb_vector_issue_sequencer;

   localparam int LANES = 2;
   localparam int VLENB = 16;
   localparam int VL_W  = 8;

   logic            CLK;
   logic            nRST;
   logic            start;
   logic [VL_W-1:0] vl;
   logic [VL_W-1:0] vstart;
   logic [1:0]      sew;
   logic            vdWiden;
   logic            reductionEna;
   logic            stall;
   logic            flush;
   logic            busy;
   logic            ena;
   logic [VL_W-1:0] elemIdx;
   logic [LANES-1:0] laneActive;
   logic [2:0]      vsRegOff;
   logic [2:0]      vdRegOff;
   logic            last;
   logic            redStep;
   logic [$clog2(LANES)-1:0] redStage;
   logic            done;
   logic            err;

   int vecCount  = 0;
   int missCount = 0;

   // Hand-computed tables for the e32, vl=7 walk
   int expIdx7  [4] = '{0, 2, 4, 6};
   int expVs7   [4] = '{0, 0, 1, 1};
   int expLane7 [4] = '{3, 3, 3, 1};
   int expLast7 [4] = '{0, 0, 0, 1};

   // Hand-computed tables for the vl=6 stall walk, cycles 1..7 after start
   int stallTab  [7] = '{0, 1, 1, 1, 0, 0, 0};
   int expIdxS   [7] = '{0, 2, 2, 2, 2, 4, 4};
   int expEnaS   [7] = '{1, 1, 1, 1, 1, 1, 0};
   int expDoneS  [7] = '{0, 0, 0, 0, 0, 0, 1};

   vector_issue_sequencer #(
      .LANES(LANES),
      .VLENB(VLENB),
      .VL_W (VL_W)
   ) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .start        (start),
      .vl           (vl),
      .vstart       (vstart),
      .sew          (sew),
      .vd_widen     (vdWiden),
      .reduction_ena(reductionEna),
      .stall        (stall),
      .flush        (flush),
      .busy         (busy),
      .ena          (ena),
      .elem_idx     (elemIdx),
      .lane_active  (laneActive),
      .vs_reg_off   (vsRegOff),
      .vd_reg_off   (vdRegOff),
      .last         (last),
      .red_step     (redStep),
      .red_stage    (redStage),
      .done         (done),
      .err          (err)
   );

   // Free-running 100 MHz clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Safety net so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts one comparison and reports it when observed differs from expected
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(negedge CLK);
   endtask

   // Presents one instruction for a single edge; returns in the first cycle
   // after the start edge
   task automatic applyStimulus(input logic [VL_W-1:0] vlIn,
                                input logic [VL_W-1:0] vstartIn,
                                input logic [1:0] sewIn,
                                input logic widenIn,
                                input logic redIn);
      start        = 1'b1;
      vl           = vlIn;
      vstart       = vstartIn;
      sew          = sewIn;
      vdWiden      = widenIn;
      reductionEna = redIn;
      nextCycle();
      start = 1'b0;
   endtask

   // Every output must read zero while reset is held
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"},      32'(busy),       32'd0);
      checkOutput({tag, "_ena"},       32'(ena),        32'd0);
      checkOutput({tag, "_elem_idx"},  32'(elemIdx),    32'd0);
      checkOutput({tag, "_lane"},      32'(laneActive), 32'd0);
      checkOutput({tag, "_vs_off"},    32'(vsRegOff),   32'd0);
      checkOutput({tag, "_vd_off"},    32'(vdRegOff),   32'd0);
      checkOutput({tag, "_last"},      32'(last),       32'd0);
      checkOutput({tag, "_red_step"},  32'(redStep),    32'd0);
      checkOutput({tag, "_red_stage"}, 32'(redStage),   32'd0);
      checkOutput({tag, "_done"},      32'(done),       32'd0);
      checkOutput({tag, "_err"},       32'(err),        32'd0);
   endtask

   // Main directed sequence
   initial begin
      nRST = 1'b0; start = 1'b0; vl = '0; vstart = '0; sew = '0;
      vdWiden = 1'b0; reductionEna = 1'b0; stall = 1'b0; flush = 1'b0;

      nextCycle();
      checkAllZero("reset");
      nRST = 1'b1;
      nextCycle();

      // e32, vl=7: four groups, tail group has only lane 0 live
      applyStimulus(8'd7, 8'd0, 2'b10, 1'b0, 1'b0);
      for (int g = 0; g < 4; g++) begin
         checkOutput("e32_ena",  32'(ena),        32'd1);
         checkOutput("e32_idx",  32'(elemIdx),    expIdx7[g]);
         checkOutput("e32_vs",   32'(vsRegOff),   expVs7[g]);
         checkOutput("e32_vd",   32'(vdRegOff),   expVs7[g]);
         checkOutput("e32_lane", 32'(laneActive), expLane7[g]);
         checkOutput("e32_last", 32'(last),       expLast7[g]);
         checkOutput("e32_done_early", 32'(done), 32'd0);
         nextCycle();
      end
      checkOutput("e32_done", 32'(done), 32'd1);
      checkOutput("e32_ena_off", 32'(ena), 32'd0);
      nextCycle();
      checkOutput("e32_done_pulse", 32'(done), 32'd0);
      checkOutput("e32_idle", 32'(busy), 32'd0);

      // e8 widening, vl=40: spot-check offsets at elements 16 and 38
      applyStimulus(8'd40, 8'd0, 2'b00, 1'b1, 1'b0);
      for (int g = 0; g < 20; g++) begin
         checkOutput("wide_idx", 32'(elemIdx), 32'(2 * g));
         if (g == 8) begin
            checkOutput("wide16_vs", 32'(vsRegOff), 32'd1);
            checkOutput("wide16_vd", 32'(vdRegOff), 32'd2);
         end
         if (g == 19) begin
            checkOutput("wide38_vs",   32'(vsRegOff),   32'd2);
            checkOutput("wide38_vd",   32'(vdRegOff),   32'd4);
            checkOutput("wide38_last", 32'(last),       32'd1);
            checkOutput("wide38_lane", 32'(laneActive), 32'd3);
         end
         nextCycle();
      end
      checkOutput("wide_done", 32'(done), 32'd1);
      nextCycle();

      // vl=6 with three stalled cycles at element 2
      applyStimulus(8'd6, 8'd0, 2'b00, 1'b0, 1'b0);
      for (int c = 0; c < 7; c++) begin
         checkOutput("stall_ena",  32'(ena),     expEnaS[c]);
         checkOutput("stall_idx",  32'(elemIdx), expIdxS[c]);
         checkOutput("stall_done", 32'(done),    expDoneS[c]);
         stall = stallTab[c][0];
         nextCycle();
      end
      stall = 1'b0;
      checkOutput("stall_idle", 32'(busy), 32'd0);

      // Empty range: no group, done in the first cycle
      applyStimulus(8'd5, 8'd5, 2'b00, 1'b0, 1'b0);
      checkOutput("empty_ena",  32'(ena),  32'd0);
      checkOutput("empty_done", 32'(done), 32'd1);
      nextCycle();
      checkOutput("empty_busy", 32'(busy), 32'd0);

      // Reserved sew: err pulse, sequencer stays idle
      applyStimulus(8'd4, 8'd0, 2'b11, 1'b0, 1'b0);
      checkOutput("err_pulse", 32'(err),  32'd1);
      checkOutput("err_busy",  32'(busy), 32'd0);
      nextCycle();
      checkOutput("err_clear", 32'(err),  32'd0);
      checkOutput("err_idle",  32'(busy), 32'd0);

      // Start during DONE is ignored; start in the following idle cycle runs
      applyStimulus(8'd2, 8'd0, 2'b00, 1'b0, 1'b0);
      checkOutput("b2b_last", 32'(last), 32'd1);
      nextCycle();
      checkOutput("b2b_done", 32'(done), 32'd1);
      start = 1'b1;
      nextCycle();
      checkOutput("b2b_ignored", 32'(busy), 32'd0);
      nextCycle();
      start = 1'b0;
      checkOutput("b2b_ena", 32'(ena), 32'd1);
      checkOutput("b2b_idx", 32'(elemIdx), 32'd0);
      nextCycle();
      checkOutput("b2b_done2", 32'(done), 32'd1);
      nextCycle();

`ifdef VECTOR_SEQ_REDUCTION_EN
      // Reduction: two groups, one fold stage, then done
      applyStimulus(8'd4, 8'd0, 2'b00, 1'b0, 1'b1);
      nextCycle();
      checkOutput("red_last", 32'(last), 32'd1);
      nextCycle();
      checkOutput("red_step",  32'(redStep),  32'd1);
      checkOutput("red_stage", 32'(redStage), 32'd0);
      checkOutput("red_ena",   32'(ena),      32'd0);
      checkOutput("red_nodone", 32'(done),    32'd0);
      nextCycle();
      checkOutput("red_done", 32'(done), 32'd1);
      nextCycle();

      // Flush during the fold stage: idle, no done pulse
      applyStimulus(8'd4, 8'd0, 2'b00, 1'b0, 1'b1);
      nextCycle();
      nextCycle();
      checkOutput("redfl_step", 32'(redStep), 32'd1);
      flush = 1'b1;
      nextCycle();
      flush = 1'b0;
      checkOutput("redfl_busy", 32'(busy),    32'd0);
      checkOutput("redfl_step0", 32'(redStep), 32'd0);
      checkOutput("redfl_done", 32'(done),    32'd0);
      nextCycle();
      checkOutput("redfl_nodone", 32'(done), 32'd0);
`else
      // Reduction flag ignored: plain two-group walk, no fold cycle
      applyStimulus(8'd4, 8'd0, 2'b00, 1'b0, 1'b1);
      nextCycle();
      checkOutput("red_last", 32'(last), 32'd1);
      nextCycle();
      checkOutput("red_done", 32'(done), 32'd1);
      checkOutput("red_step", 32'(redStep), 32'd0);
      nextCycle();

      // Flush on the last group wins over acceptance: idle, no done pulse
      applyStimulus(8'd4, 8'd0, 2'b00, 1'b0, 1'b0);
      nextCycle();
      checkOutput("flush_last", 32'(last), 32'd1);
      flush = 1'b1;
      nextCycle();
      flush = 1'b0;
      checkOutput("flush_busy", 32'(busy), 32'd0);
      checkOutput("flush_ena",  32'(ena),  32'd0);
      checkOutput("flush_done", 32'(done), 32'd0);
      nextCycle();
      checkOutput("flush_nodone", 32'(done), 32'd0);
`endif

      // Asynchronous reset in the middle of a vl=20 walk
      applyStimulus(8'd20, 8'd0, 2'b00, 1'b0, 1'b0);
      nextCycle();
      nextCycle();
      nextCycle();
      checkOutput("midrst_idx", 32'(elemIdx), 32'd6);
      nRST = 1'b0;
      #1;
      checkAllZero("midrst");
      nextCycle();
      nRST = 1'b1;
      nextCycle();
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_ena",  32'(ena),  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
